// File: rtl/bus_wrr_arbiter_pkg.sv
// bus_arb_pkg: shared types and helpers for the weighted round-robin bus arbiter.
//   arb_state_e : arbiter FSM states.
//   ID_W        : width of the destination field at the top of each packet.
//   dest_of     : extracts the destination byte from a packet of a given width.
//   push_mask   : delivery lanes for a destination/source pair.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, POP, PUSH} arb_state_e;

    localparam int unsigned ID_W      = 8;
    // Upper bounds for the helper functions; packets and driver counts must fit.
    localparam int unsigned MAX_PKT_W = 64;
    localparam int unsigned MAX_DRVRS = 16;

    // Destination is the top ID_W bits of a packet that is sz bits wide.
    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                input int unsigned sz);
        return ID_W'(pkt >> (sz - ID_W));
    endfunction

    // Broadcast hits every driver except the source; a unicast hits only a valid
    // driver other than the source; anything else yields an empty mask (drop).
    function automatic logic [MAX_DRVRS-1:0] push_mask(input logic [ID_W-1:0] dest,
                                                       input int unsigned src,
                                                       input logic [ID_W-1:0] broadcast,
                                                       input int unsigned n);
        logic [MAX_DRVRS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_DRVRS; i++) begin
            if (i < n && i != src && (dest == broadcast || dest == ID_W'(i))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_wrr_arbiter_if.sv
// bus_wrr_arbiter_if: driver-FIFO bus between the arbiter and its drivers.
//   pndng/D_pop         : per-driver FIFO non-empty flag and head packet.
//   pop                 : one-hot FIFO read strobe.
//   push/D_push         : delivery strobes and delivered packet (all lanes equal).
//   cfg_we/id/quota     : per-driver burst quota programming.
//   busy/grant_id       : arbiter activity and current/last granted driver.
//   err_drop            : pulse when a packet is discarded.
// Modport master is the arbiter side, slave is the driver/testbench side.
interface bus_wrr_arbiter_if #(
    parameter int unsigned drvrs   = 4,
    parameter int unsigned pckg_sz = 16,
    parameter int unsigned QW      = 4
);
    localparam int unsigned IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    logic [drvrs-1:0]              pndng;
    logic [drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]              pop;
    logic [drvrs-1:0]              push;
    logic [drvrs-1:0][pckg_sz-1:0] D_push;
    logic                          cfg_we;
    logic [IW-1:0]                 cfg_id;
    logic [QW-1:0]                 cfg_quota;
    logic                          busy;
    logic [IW-1:0]                 grant_id;
    logic                          err_drop;

    modport master (
        input  pndng, D_pop, cfg_we, cfg_id, cfg_quota,
        output pop, push, D_push, busy, grant_id, err_drop
    );

    modport slave (
        output pndng, D_pop, cfg_we, cfg_id, cfg_quota,
        input  pop, push, D_push, busy, grant_id, err_drop
    );

endinterface

// File: rtl/bus_wrr_arbiter_rr_pick.sv
// rr_pick: combinational wrapping priority picker.
//   req     : request vector.
//   ptr     : position with highest priority; priority falls off with wrapping distance.
//   gnt_id  : first set request at or after ptr.
//   gnt_vld : any request set.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_vld
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        // Scan from the farthest offset back toward ptr so the nearest request wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % int'(N));
            if (req[idx]) begin
                gnt_id  = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_wrr_arbiter.sv
// bus_wrr_arbiter: weighted round-robin arbiter and packet router for driver FIFOs.
// Grants one driver at a time for up to quota[driver] packets, pops each packet and
// pushes it to its destination driver, to all other drivers on broadcast, or drops it.
//   clk   : rising-edge clock.
//   reset : asynchronous, active-high.
//   bus   : driver bus (see bus_wrr_arbiter_if), master side.
module bus_wrr_arbiter import bus_arb_pkg::*; #(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF,
    parameter int unsigned     QW        = 4,
    localparam int unsigned    IW        = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input logic              clk,
    input logic              reset,
    bus_wrr_arbiter_if.master bus
);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [QW-1:0]    cnt_q, cnt_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [QW-1:0]    quota_q [drvrs];

    logic [IW-1:0]    pick_id;
    logic             pick_vld;
    logic [IW-1:0]    next_ptr;
    logic [drvrs-1:0] mask;

    rr_pick #(.N(drvrs)) u_pick (
        .req     (bus.pndng),
        .ptr     (rr_ptr_q),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    assign next_ptr     = (grant_q == IW'(drvrs - 1)) ? '0 : grant_q + IW'(1);
    assign bus.grant_id = grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        pkt_d        = pkt_q;
        bus.pop      = '0;
        bus.push     = '0;
        bus.D_push   = '0;
        bus.err_drop = 1'b0;
        bus.busy     = (state_q != IDLE);
        mask = drvrs'(push_mask(dest_of(MAX_PKT_W'(pkt_q), pckg_sz), 32'(grant_q),
                                broadcast, drvrs));

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_id;
                    // Quota is sampled only here, so writes never alter a running burst.
                    cnt_d   = quota_q[pick_id];
                    state_d = POP;
                end
            end
            POP: begin
                if (bus.pndng[grant_q]) begin
                    bus.pop[grant_q] = 1'b1;
                    pkt_d            = bus.D_pop[grant_q];
                    state_d          = PUSH;
                end else begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            PUSH: begin
                bus.D_push   = {drvrs{pkt_q}};
                bus.push     = mask;
                bus.err_drop = (mask == '0);
                cnt_d        = cnt_q - QW'(1);
                if (cnt_d != '0 && bus.pndng[grant_q]) begin
                    state_d = POP;
                end else begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            pkt_q    <= '0;
            for (int i = 0; i < int'(drvrs); i++) begin
                quota_q[i] <= QW'(1);
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            pkt_q    <= pkt_d;
            if (bus.cfg_we && 32'(bus.cfg_id) < drvrs) begin
                // A zero quota would never end a burst cleanly; store it as one.
                quota_q[bus.cfg_id] <= (bus.cfg_quota == '0) ? QW'(1) : bus.cfg_quota;
            end
        end
    end

endmodule

// File: doc/bus_wrr_arbiter.md
# bus_wrr_arbiter

Weighted round-robin arbiter and packet router for the shared bus between `drvrs` driver FIFOs. It watches each driver's pending flag, grants one driver at a time for a programmable burst of packets, pops each packet, decodes the destination byte and pushes the packet to one target or, on broadcast, to all other drivers. It replaces the hard-wired selection loop in the bus generator and gives the testbench per-driver bandwidth control and drop/error visibility.

## Interface
- `drvrs`, 4: number of drivers/requesters (2..16).
- `pckg_sz`, 16: packet width in bits (≥ 9).
- `broadcast`, 8'hFF: destination ID meaning "all drivers except source".
- `QW`, 4: quota field width; quota range 1..2^QW-1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pndng` in [drvrs-1:0]: driver FIFO non-empty.
- `D_pop` in [drvrs-1:0][pckg_sz-1:0]: head-of-FIFO packet per driver, valid while `pndng`.
- `pop` out [drvrs-1:0]: one-hot, 1-cycle FIFO read strobe.
- `push` out [drvrs-1:0]: delivery strobe(s) to destination driver(s).
- `D_push` out [drvrs-1:0][pckg_sz-1:0]: delivered packet, same value on every lane.
- `cfg_we` in 1: quota write strobe.
- `cfg_id` in [$clog2(drvrs)-1:0]: driver whose quota is written.
- `cfg_quota` in [QW-1:0]: packets per grant; 0 is stored as 1.
- `busy` out 1: high in any state except IDLE.
- `grant_id` out [$clog2(drvrs)-1:0]: current or last granted driver.
- `err_drop` out 1: 1-cycle pulse when a packet is discarded.

## Operation
- Destination = `pkt[pckg_sz-1 -: 8]`.
- FSM states: IDLE, POP, PUSH.
  - IDLE: if any `pndng`, pick the first set bit at or after `rr_ptr` (wrapping), latch as `grant_id`, load the burst counter with `quota[grant_id]`, then go to POP.
  - POP: if `pndng[grant_id]`, assert `pop[grant_id]`, latch `D_pop[grant_id]` and go to PUSH. Otherwise set `rr_ptr = grant_id+1` and go to IDLE with no pop.
  - PUSH: drive the latched packet on all `D_push` lanes and decrement the burst counter.
    - dest == `broadcast`: `push` = all ones except `grant_id`.
    - dest < drvrs and dest != grant_id: `push` = one-hot dest.
    - any other dest, including self and out of range: no push, `err_drop` pulses.
    - Next state is POP if the counter is still nonzero and `pndng[grant_id]` is set. Otherwise set `rr_ptr = grant_id+1` (mod drvrs) and go to IDLE.
- Quota table: one register per driver, reset to 1. `cfg_we` updates it in any state; a new value applies at the next IDLE→POP load, never mid-burst.
- `rr_ptr` wraps from drvrs-1 to 0.
- Reset (asynchronous, at any point):
  - State returns to IDLE; `rr_ptr` = 0; quotas = 1.
  - `pop`, `push`, `D_push`, `busy`, `grant_id` and `err_drop` all go to 0.
  - A latched in-flight packet is discarded without a push.

## Timing
- `pndng` sampled high in IDLE at edge n → `pop` high in cycle n+1 → `push` high in cycle n+2.
- Within a burst, one packet every 2 cycles (POP/PUSH alternate).
- One IDLE cycle between grants.
- `pop` and `push` are each high for exactly one cycle per packet and are never high in the same cycle.
- `err_drop` is coincident with the PUSH cycle of the dropped packet.
- Quota write and grant load in the same cycle: the old value is loaded.

## Structure
- Package `bus_arb_pkg`:
  - state enum `arb_state_e` {IDLE, POP, PUSH}
  - localparam `ID_W = 8`
  - function `dest_of(pkt)`
  - function `push_mask(dest, src, broadcast)`
- Sub-module `rr_pick`: combinational wrapping priority picker (req, ptr → gnt_id, gnt_vld), reusable by the checker model.

## Test plan
- Reset, then `pndng=4'b0100` with D_pop[2]=16'h0155 → pop=4'b0100 at cycle 1, push=4'b0010 with D_push=16'h0155 at cycle 2, then `busy` drops.
- All `pndng` high, quotas 1, each driver holding one packet → grant order 0,1,2,3 and `rr_ptr` returns to 0.
- cfg quota[1]=3, driver 1 holding 5 packets and driver 2 holding 1 → pops from 1,1,1 then 2 then 1,1; the 2-cycle packet spacing holds inside each burst.
- Driver 3 sends 16'hFF23 → push=4'b0111. Driver 0 sends 16'h0711 (dest 7) and 16'h0022 (self) → each gives an `err_drop` pulse and no push.
- `reset` asserted in PUSH cycle → `push` never asserts for that packet; all outputs 0 asynchronously; after release the next grant starts from driver 0.
- `pndng[grant_id]` deasserts before POP → no pop, returns to IDLE, next grant goes to grant_id+1.
